load_store_unit: RTL and testbench

Data-memory stage of the MIPS core: takes the byte address produced by the ALU and the store operand read from the register file, performs a load or store against an internal word-organised synchronous RAM, and returns sign- or zero-extended load data for register write-back. Multicycle with a valid/ready request and a single-cycle response pulse, so the PC/register clocking can stall on it instead of relying on a fixed divider phase.

---
 rtl/load_store_unit.sv | 217 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-memory stage of the MIPS core. A request is taken through a valid/ready
// handshake, the internal word-organised synchronous RAM is read or written
// during the ACCESS cycle, and a single-cycle response pulse follows in RESP.
// The PC/register clocking stalls on the handshake and the response pulse.
//
// Configuration macro: LSU_SUBWORD_EN
//   defined   : byte and halfword loads/stores with little-endian lane select
//               and sign/zero extension on loads.
//   undefined : word accesses only; byte, halfword and reserved sizes return
//               an error response and never touch the RAM.
//
// Parameters
//   ADDR_WIDTH   word-address bits, RAM depth = 2**ADDR_WIDTH 32-bit words
//
// Ports
//   clock         single clock, rising-edge
//   reset         synchronous, active-high
//   req_valid     request present
//   req_ready     unit accepts a request this cycle (IDLE and not in reset)
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 reserved
//   req_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   req_address   byte address from the ALU
//   req_wdata     store data, sub-word data in the low bits
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data, 0 for stores, errors and idle cycles
//   resp_error    request rejected, qualified by resp_valid
//   busy          unit is not in IDLE
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;

  // Request fields captured at the accept edge; the requester may change its
  // inputs freely afterwards.
  logic                  write_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
`ifdef LSU_SUBWORD_EN
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [1:0]            lane_q;
`endif

  logic        range_err;
  logic        size_err;
  logic        req_err;
  logic        do_access;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] load_ext;
  logic [31:0] rd_word_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

`ifndef LSU_SUBWORD_EN
  // Word-only build never looks at the extension select.
  logic unused_unsigned;
  assign unused_unsigned = req_unsigned;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Fixed three-cycle sequence; the response has no back-pressure.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Error is decided from the raw request so it can be latched with it.
  // Any address bit above the RAM's byte range rejects the request.
  always_comb begin
    range_err = (req_address >> (ADDR_WIDTH + 2)) != 32'd0;
`ifdef LSU_SUBWORD_EN
    case (req_size)
      2'b00:   size_err = 1'b0;
      2'b01:   size_err = req_address[0];
      2'b10:   size_err = |req_address[1:0];
      default: size_err = 1'b1;
    endcase
`else
    size_err = (req_size != 2'b10) || (req_address[1:0] != 2'b00);
`endif
    req_err = range_err || size_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
`ifdef LSU_SUBWORD_EN
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
`endif
    end else if (accept) begin
      write_q    <= req_write;
      err_q      <= req_err;
      idx_q      <= req_address[ADDR_WIDTH+1:2];
      wdata_q    <= req_wdata;
`ifdef LSU_SUBWORD_EN
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      lane_q     <= req_address[1:0];
`endif
    end
  end

  // Reset during ACCESS cancels the RAM operation at that same edge.
  assign do_access = (state == ACCESS) && !err_q && !reset;

  // Sub-word store data is replicated across lanes so the byte enables alone
  // pick where it lands.
  always_comb begin
`ifdef LSU_SUBWORD_EN
    case (size_q)
      2'b00: begin
        byte_en  = 4'b0001 << lane_q;
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en  = lane_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = wdata_q;
      end
    endcase
`else
    byte_en  = 4'b1111;
    wr_lanes = wdata_q;
`endif
  end

  // RAM array, no reset so it maps onto block memory.
  always_ff @(posedge clock) begin
    if (do_access && write_q) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[idx_q][8*k +: 8] <= wr_lanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                        rd_word_q <= '0;
    else if (do_access && !write_q)   rd_word_q <= mem[idx_q];
  end

  // Lane extraction and extension of the word read during ACCESS.
  always_comb begin
`ifdef LSU_SUBWORD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = rd_word_q[8*lane_q +: 8];
    half_sel = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'd0, byte_sel}
                                     : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = unsigned_q ? {16'd0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
      default: load_ext = rd_word_q;
    endcase
`else
    load_ext = rd_word_q;
`endif
  end

  assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_ext : 32'd0;
  assign resp_error = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. Directed steps from the test plan
// followed by randomized loads/stores checked against a byte-addressed
// reference memory. Handshake timing, idle output values and reset behaviour
// are checked on every transaction.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int AW = 10;
`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference memory, one entry per byte address.
  logic [7:0] mdl [int];

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input string what,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, what, observed, expected);
    end
  endtask

  // Behavioural model: error rules, byte-wise store, byte-wise load + extend.
  task automatic modelOp(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
    int nbytes;
    logic [31:0] v;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = (sz == 2'b11) || (addr % nbytes != 0) || (addr >= 32'(4 * (2 ** AW)));
    if (!SUBWORD && sz != 2'b10) err = 1'b1;
    rd = 32'd0;
    if (!err && wr) begin
      for (int i = 0; i < nbytes; i++) mdl[int'(addr) + i] = wd[8*i +: 8];
    end else if (!err) begin
      v = 32'd0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(mdl[int'(addr) + i]) << (8 * i));
      if (nbytes < 4 && !uns && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
      rd = v;
    end
  endtask

  // One full request/response; checks protocol timing and model results.
  task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wd,
                               output logic obs_err, output logic [31:0] obs_rd);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          waited;
    obs_err = 1'b0;
    obs_rd  = 32'd0;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_address = addr; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      checkOutput(tag, "ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    modelOp(wr, sz, uns, addr, wd, exp_err, exp_rd);
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_address = $urandom; req_wdata = $urandom;
    checkOutput(tag, "acc_ready", 32'(req_ready), 32'd0);
    checkOutput(tag, "acc_valid", 32'(resp_valid), 32'd0);
    checkOutput(tag, "acc_busy", 32'(busy), 32'd1);
    @(negedge clock);
    checkOutput(tag, "resp_ready", 32'(req_ready), 32'd0);
    checkOutput(tag, "resp_valid", 32'(resp_valid), 32'd1);
    checkOutput(tag, "resp_error", 32'(resp_error), 32'(exp_err));
    checkOutput(tag, "resp_rdata", resp_rdata, exp_rd);
    obs_err = resp_error;
    obs_rd  = resp_rdata;
    @(negedge clock);
    checkOutput(tag, "idle_valid", 32'(resp_valid), 32'd0);
    checkOutput(tag, "idle_rdata", resp_rdata, 32'd0);
    checkOutput(tag, "idle_error", 32'(resp_error), 32'd0);
    checkOutput(tag, "idle_busy", 32'(busy), 32'd0);
    checkOutput(tag, "idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    logic        rw;
    logic [1:0]  rsz;
    logic [31:0] ra;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_address = 32'd0; req_wdata = 32'd0;

    // Reset values.
    repeat (3) @(negedge clock);
    checkOutput("reset", "ready", 32'(req_ready), 32'd0);
    checkOutput("reset", "valid", 32'(resp_valid), 32'd0);
    checkOutput("reset", "rdata", resp_rdata, 32'd0);
    checkOutput("reset", "error", 32'(resp_error), 32'd0);
    checkOutput("reset", "busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset", "ready_after", 32'(req_ready), 32'd1);

    // Word store / load.
    applyStimulus("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, e, r);
    applyStimulus("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, r);
    checkOutput("lw10", "const", r, 32'h1234_5678);

`ifdef LSU_SUBWORD_EN
    applyStimulus("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, e, r);
    applyStimulus("lbs11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, e, r);
    checkOutput("lbs11", "const", r, 32'hFFFF_FFAB);
    applyStimulus("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, e, r);
    checkOutput("lbu11", "const", r, 32'h0000_00AB);
    applyStimulus("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, r);
    checkOutput("lw10b", "const", r, 32'h1234_AB78);
    applyStimulus("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, e, r);
    applyStimulus("lhs12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, e, r);
    checkOutput("lhs12", "const", r, 32'hFFFF_BEEF);
    applyStimulus("lw10h", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, r);
    checkOutput("lw10h", "const", r, 32'hBEEF_AB78);
`else
    applyStimulus("sb10", 1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_00AB, e, r);
    checkOutput("sb10", "const_err", 32'(e), 32'd1);
    applyStimulus("lw10n", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, r);
    checkOutput("lw10n", "const", r, 32'h1234_5678);
`endif

    // Error cases: misaligned word, misaligned half store, out of range.
    applyStimulus("lw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, e, r);
    checkOutput("lw13", "const_err", 32'(e), 32'd1);
    checkOutput("lw13", "const_rdata", r, 32'd0);
    applyStimulus("sh11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5555, e, r);
    checkOutput("sh11", "const_err", 32'(e), 32'd1);
    applyStimulus("sw1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h5555_5555, e, r);
    checkOutput("sw1000", "const_err", 32'(e), 32'd1);
    applyStimulus("lw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, e, r);
    checkOutput("lw1000", "const_err", 32'(e), 32'd1);
    applyStimulus("lw10e", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, r);
    checkOutput("lw10e", "const", r, SUBWORD ? 32'hBEEF_AB78 : 32'h1234_5678);

    // Reset during ACCESS cancels a store and its response.
    applyStimulus("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, e, r);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_address = 32'h20; req_wdata = 32'hDEAD_BEEF;
    checkOutput("rst_acc", "ready_pre", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    checkOutput("rst_acc", "busy_acc", 32'(busy), 32'd1);
    @(negedge clock);
    checkOutput("rst_acc", "valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_acc", "busy", 32'(busy), 32'd0);
    checkOutput("rst_acc", "ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_acc", "valid_after", 32'(resp_valid), 32'd0);
    checkOutput("rst_acc", "ready_after", 32'(req_ready), 32'd1);
    applyStimulus("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e, r);
    checkOutput("lw20", "const", r, 32'hCAFE_F00D);

    // Randomized traffic over a pre-initialised region.
    for (int i = 0; i < 16; i++)
      applyStimulus("init", 1'b1, 2'b10, 1'b0, 32'h100 + 32'(4 * i), $urandom, e, r);
    for (int i = 0; i < 80; i++) begin
      rw  = 1'($urandom);
      rsz = 2'($urandom_range(0, 3));
      ra  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(12, 31));
      applyStimulus("rand", rw, rsz, 1'($urandom), ra, $urandom, e, r);
    end
    for (int i = 0; i < 16; i++)
      applyStimulus("final", 1'b0, 2'b10, 1'b0, 32'h100 + 32'(4 * i), 32'h0, e, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
